// File: rtl/slave_port.sv
// rtl/slave_port.sv - serial bus slave port: deserialise addr/wdata, access memory, serialise read data
module slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter bit SPLIT_EN   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  swdata,
  input  logic                  smode,
  input  logic                  mvalid,
  output logic                  srdata,
  output logic                  svalid,
  output logic                  sready,
  output logic                  ssplit,
  input  logic                  split_grant,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  // One counter serves address, write-data and read-data phases, so it is
  // sized for the wider of the two fields.
  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_MWRITE,
    S_MREAD,
    S_RWAIT,
    S_SGNT,
    S_RDATA
  } state_t;

  state_t                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [CW-1:0]           cnt_inc;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_upd;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   wdata_upd;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    rd_next_bit;
  logic                    mode_q;
  logic                    srdata_q;
  logic                    svalid_q;
  logic                    ssplit_q;
  logic                    mem_wen_q;
  logic                    mem_ren_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;

  logic addr_last;
  logic data_last;

  assign cnt_inc   = cnt_q + CW'(1);
  assign addr_last = (cnt_q == CW'(ADDR_WIDTH - 1));
  assign data_last = (cnt_q == CW'(DATA_WIDTH - 1));

  // Shift registers with the incoming serial bit dropped into the slot the
  // counter points at; the last bit of a field can then go straight to memory.
  always_comb begin
    addr_upd  = addr_q;
    wdata_upd = wdata_q;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      if (cnt_q == CW'(i)) addr_upd[i] = swdata;
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (cnt_q == CW'(i)) wdata_upd[i] = swdata;
    end
  end

  // Next read-data bit to present on srdata during the serial read burst.
  always_comb begin
    rd_next_bit = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (cnt_inc == CW'(i)) rd_next_bit = rdata_q[i];
    end
  end

  // Transaction FSM with registered bus and memory outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mode_q      <= 1'b0;
      srdata_q    <= 1'b0;
      svalid_q    <= 1'b0;
      ssplit_q    <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      // Memory strobes are single-cycle pulses by default.
      mem_wen_q <= 1'b0;
      mem_ren_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (mvalid) begin
            addr_q  <= addr_upd;
            mode_q  <= smode;
            cnt_q   <= CW'(1);
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (mvalid) begin
            addr_q <= addr_upd;
            if (addr_last) begin
              cnt_q <= '0;
              if (mode_q) begin
                state_q <= S_WDATA;
              end else begin
                mem_ren_q  <= 1'b1;
                mem_addr_q <= addr_upd;
                state_q    <= S_MREAD;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        S_WDATA: begin
          if (mvalid) begin
            wdata_q <= wdata_upd;
            if (data_last) begin
              cnt_q       <= '0;
              mem_wen_q   <= 1'b1;
              mem_addr_q  <= addr_q;
              mem_wdata_q <= wdata_upd;
              state_q     <= S_MWRITE;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
        end
        S_MWRITE: begin
          state_q <= S_IDLE;
        end
        S_MREAD: begin
          ssplit_q <= SPLIT_EN;
          state_q  <= S_RWAIT;
        end
        S_RWAIT: begin
          if (mem_rvalid) begin
            rdata_q <= mem_rdata;
            if (SPLIT_EN) begin
              ssplit_q <= 1'b0;
              state_q  <= S_SGNT;
            end else begin
              svalid_q <= 1'b1;
              srdata_q <= mem_rdata[0];
              state_q  <= S_RDATA;
            end
          end
        end
        S_SGNT: begin
          if (split_grant) begin
            svalid_q <= 1'b1;
            srdata_q <= rdata_q[0];
            state_q  <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (data_last) begin
            svalid_q <= 1'b0;
            srdata_q <= 1'b0;
            cnt_q    <= '0;
            state_q  <= S_IDLE;
          end else begin
            srdata_q <= rd_next_bit;
            cnt_q    <= cnt_inc;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign sready    = (state_q == S_IDLE);
  assign srdata    = srdata_q;
  assign svalid    = svalid_q;
  assign ssplit    = ssplit_q;
  assign mem_wen   = mem_wen_q;
  assign mem_ren   = mem_ren_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/slave_port.md
Name: slave_port

Overview:
- Bus-side responder paired with the serial master port.
- Deserialises the memory address and write data that the master shifts onto the serial bus (LSB first, qualified by mvalid).
- Issues a single-word read or write to the attached slave memory.
- For reads, serialises the returned word back to the master on srdata/svalid. Optionally signals a split while a slow memory read is outstanding.
- Sits between the address decoder's per-slave routing (mvalid already gated to this slave) and one memory device.

Parameters:
- ADDR_WIDTH, 12, slave memory address width (bits shifted in per transaction); must be >= 2.
- DATA_WIDTH, 8, data word width; must be >= 2.
- SPLIT_EN, 0, 1 = assert ssplit while a read is pending in memory.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- swdata  input  1  serial address / write-data bit from the master.
- smode  input  1  transaction mode from the master: 0 read, 1 write; sampled with the first address bit.
- mvalid  input  1  swdata valid, decoder-gated to this slave.
- srdata  output  1  serial read-data bit to the master.
- svalid  output  1  srdata valid.
- sready  output  1  high when idle and able to accept a new transaction.
- ssplit  output  1  split request to the arbiter (SPLIT_EN=1 only).
- split_grant  input  1  arbiter has re-granted the bus to the split master.
- mem_addr  output  ADDR_WIDTH  memory address.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_wen  output  1  one-cycle write strobe.
- mem_ren  output  1  one-cycle read strobe.
- mem_rdata  input  DATA_WIDTH  memory read data.
- mem_rvalid  input  1  mem_rdata valid (pulse, any latency >= 1 cycle after mem_ren).

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; counter, addr, wdata, rdata and mode cleared.
  - Outputs after reset: srdata=0, svalid=0, ssplit=0, mem_wen=0, mem_ren=0, mem_addr=0, mem_wdata=0, sready=1.
  - Reset mid-transaction abandons it; a partially received write never reaches memory.
- All outputs are registered except sready, which equals (state==IDLE).
- Bits are consumed only on cycles with mvalid=1. Gaps with mvalid=0 hold the counter. mvalid is ignored in MWRITE, MREAD, RWAIT and RDATA.
- IDLE: on mvalid=1, set addr[0]<=swdata, mode<=smode, counter<=1, then go to ADDR.
- ADDR: on mvalid=1, set addr[counter]<=swdata.
  - If counter==ADDR_WIDTH-1: counter<=0, then go to WDATA if mode=1, else MREAD.
  - Otherwise counter++.
- WDATA: on mvalid=1, set wdata[counter]<=swdata; on the last bit (counter==DATA_WIDTH-1) counter<=0 and go to MWRITE.
- MWRITE: mem_wen=1 for exactly one cycle with mem_addr=addr and mem_wdata=wdata, then go to IDLE.
- MREAD: mem_ren=1 for exactly one cycle with mem_addr=addr, then go to RWAIT. If SPLIT_EN=1, ssplit<=1 on entry to RWAIT.
- RWAIT: on mem_rvalid=1, rdata<=mem_rdata.
  - SPLIT_EN=0: go to RDATA.
  - SPLIT_EN=1: ssplit<=0, then wait in SGNT.
- SGNT: wait for split_grant=1, then go to RDATA. split_grant in any other state is ignored.
- RDATA: svalid=1 and srdata=rdata[counter] for DATA_WIDTH consecutive cycles, LSB first.
  - After the last bit: svalid<=0, counter<=0, go to IDLE.
- Write latency: last data bit sampled at edge N; mem_wen high in cycle N+1; sready high at N+2.
- Read latency (SPLIT_EN=0): mem_ren is high the cycle after the last address bit. svalid rises the cycle after mem_rvalid and stays high for exactly DATA_WIDTH cycles.
- mem_rvalid outside RWAIT is ignored. mem_addr and mem_wdata hold their last values between transactions.

Test Plan:
- Write: serialise addr 0xA5C, mode=1, data 0x3B with mvalid continuous -> mem_wen single pulse with mem_addr=0xA5C, mem_wdata=0x3B; sready=1 two cycles after the last bit.
- Read, 2-cycle memory latency, mem_rdata=0xC6 -> mem_ren pulse with mem_addr=0x123; svalid high for 8 cycles; srdata sequence 0,1,1,0,0,0,1,1.
- Gapped write: mvalid=0 for 3 cycles inside the address and data bits (addr 0x001, data 0x80) -> same single mem_wen with mem_addr=0x001, mem_wdata=0x80; no extra strobes.
- SPLIT_EN=1 read, memory latency 6 -> ssplit=1 from RWAIT entry until mem_rvalid. No svalid until split_grant; split_grant raised 4 cycles later -> 8-bit svalid burst starts the next cycle.
- rst pulsed after 5 of 8 write-data bits -> no mem_wen. All outputs return to reset values. A following read of 0x000 completes normally.
- Back-to-back: write 0x7FF<=0xFF, then read 0x7FF with memory echoing 0xFF -> svalid burst of eight 1s; sready=0 for the whole of each transaction.
